status_flag_unit: RTL
=====================

// Module: status_flag_unit
// PURPOSE
//  Producer side of the NZCV status register read by the condition checker.
//  Derives N/Z/C/V from the EXE-stage ALU result and commits them to the status
//  register when the S bit is set. Provides a forwarded flag view and a stall
//  request for a conditional instruction in ID. Holds a one-deep shadow copy
//  for exception save/restore.
// PARAMETERS
//  DATA_W   32  ALU datapath width
//  FORWARD  1   1: bypass pending flags to ID; 0: stall ID on flag hazard
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous reset, active-low
//  exe_valid    in   1       EXE stage holds a real instruction
//  exe_s        in   1       instruction updates flags (S bit)
//  exe_cmd      in   4       ALU cmd: 0001 MOV,1001 MVN,0010 ADD,0011 ADC,0100 SUB,
//                            0101 SBC,0110 AND,0111 ORR,1000 EOR
//  alu_res      in   DATA_W  ALU result
//  alu_cout     in   1       ALU carry out (for SUB/SBC: 1 = no borrow)
//  op_a_msb     in   1       MSB of operand A
//  op_b_msb     in   1       MSB of operand B as fed to the ALU
//  freeze       in   1       pipeline freeze; no commit this cycle
//  flush        in   1       cancels the EXE instruction's flag update
//  id_cond      in   4       condition field of the ID instruction
//  save_req     in   1       copy status register to shadow
//  restore_req  in   1       copy shadow to status register
//  status       out  4       committed {N,Z,C,V}
//  status_id    out  4       flags the ID condition checker must use
//  hazard_stall out  1       request to stall ID one cycle
// BEHAVIOUR
//  - Reset (rst_n=0, async): status=0, shadow=0, hazard_stall=0, status_id=0.
//  - Combinational next flags nf, computed from EXE inputs:
//    N=alu_res[DATA_W-1]; Z=(alu_res==0) for every cmd.
//    ADD/ADC: C=alu_cout; V=(a_msb==b_msb)&&(res_msb!=a_msb).
//    SUB/SBC: C=alu_cout; V=(a_msb!=b_msb)&&(res_msb!=a_msb).
//    MOV/MVN/AND/ORR/EOR and any other code: C,V keep committed values.
//  - upd = exe_valid & exe_s & ~flush & ~freeze.
//  - Priority at each edge: restore_req > upd > hold. restore_req loads
//    status<=shadow and discards a simultaneous upd.
//  - save_req: shadow<=status value before this edge, i.e. the pre-update
//    value even when upd is active in the same cycle.
//  - save_req with restore_req: shadow and status swap.
//  - 1-cycle latency: status reflects the instruction on the edge after upd.
//  - status_id (combinational): nf when FORWARD=1 and upd; shadow when
//    restore_req; otherwise status.
//  - hazard_stall (registered): FORWARD=0 only. Set for one cycle on the edge
//    where upd=1 and id_cond!=4'b1110. Held while freeze=1. Cleared on the next
//    edge with freeze=0, by flush, or by restore_req. Constant 0 when FORWARD=1.
//  - Reset mid-operation: all state cleared at once; no pending update survives.
//  - freeze holds status, shadow and hazard_stall; save/restore also blocked.
// TESTING
//  - ADD 0x7FFFFFFF+1, S=1: status=4'b1001 (N,V) after one edge; C=0,Z=0.
//  - SUB 5-5, cout=1, S=1: status=4'b0110 (Z,C); the same op with S=0 leaves status unchanged.
//  - status=4'b0011, then AND result 0, S=1: status=4'b0111 (C,V preserved).
//  - FORWARD=1, ADD giving Z=1 with S=1 in EXE: status_id=4'b0100 in the same cycle
//    while status is still old; hazard_stall stays 0.
//  - FORWARD=0, upd with id_cond=0000: hazard_stall=1 for exactly one cycle;
//    id_cond=1110 gives no stall; freeze holds the stall.
//  - save_req (status=1010), then upd to 0100, then restore_req with a concurrent
//    upd: status=1010; rst_n pulse mid-sequence clears status and shadow to 0.

Source files
------------

// File: rtl/status_flag_unit.sv
`default_nettype none
// ============================================================================
// status_flag_unit : NZCV status register producer with ID forwarding/stall
//                    and a one-deep shadow copy for exception save/restore.
// Revision 1.0
// ============================================================================
module status_flag_unit #(
  parameter int DATA_W  = 32,
  parameter bit FORWARD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exe_valid,
  input  logic              exe_s,
  input  logic [3:0]        exe_cmd,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_cout,
  input  logic              op_a_msb,
  input  logic              op_b_msb,
  input  logic              freeze,
  input  logic              flush,
  input  logic [3:0]        id_cond,
  input  logic              save_req,
  input  logic              restore_req,
  output logic [3:0]        status,
  output logic [3:0]        status_id,
  output logic              hazard_stall
);

  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] COND_AL = 4'b1110;

  logic [3:0] r_status;
  logic [3:0] r_shadow;
  logic       r_stall;
  logic [3:0] w_nf;
  logic       w_upd;
  logic       w_res_msb;

  assign w_upd     = exe_valid & exe_s & ~flush & ~freeze;
  assign w_res_msb = alu_res[DATA_W-1];

  // Non-arithmetic commands leave C and V at their committed values.
  always_comb begin
    w_nf = {w_res_msb, (alu_res == '0), r_status[1], r_status[0]};
    case (exe_cmd)
      CMD_ADD, CMD_ADC: begin
        w_nf[1] = alu_cout;
        w_nf[0] = (op_a_msb == op_b_msb) && (w_res_msb != op_a_msb);
      end
      CMD_SUB, CMD_SBC: begin
        w_nf[1] = alu_cout;
        w_nf[0] = (op_a_msb != op_b_msb) && (w_res_msb != op_a_msb);
      end
      default: ;
    endcase
  end

  // Shadow captures the pre-edge status, so save+restore swaps the two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= 4'b0000;
      r_shadow <= 4'b0000;
      r_stall  <= 1'b0;
    end else if (!freeze) begin
      if (restore_req) begin
        r_status <= r_shadow;
      end else if (w_upd) begin
        r_status <= w_nf;
      end
      if (save_req) begin
        r_shadow <= r_status;
      end
      r_stall <= (FORWARD == 1'b0) && w_upd && !restore_req && (id_cond != COND_AL);
    end
  end

  assign status       = r_status;
  assign hazard_stall = r_stall;
  assign status_id    = (FORWARD && w_upd) ? w_nf : (restore_req ? r_shadow : r_status);

endmodule
`default_nettype wire
